// File: rtl/mul_arbiter_if.sv
// Request/response channels for two requesters plus the shared multiplier port.
`timescale 1ns/1ps
interface mul_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_signed;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_signed;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [63:0] rsp0_product;
    logic        rsp0_err;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [63:0] rsp1_product;
    logic        rsp1_err;

    logic        mul_start;
    logic [31:0] mul_multiplicand;
    logic [31:0] mul_multiplier;
    logic [63:0] mul_product;
    logic        mul_finish;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_signed,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_signed,
        output req1_ready,
        output rsp0_valid, rsp0_product, rsp0_err,
        input  rsp0_ready,
        output rsp1_valid, rsp1_product, rsp1_err,
        input  rsp1_ready,
        output mul_start, mul_multiplicand, mul_multiplier,
        input  mul_product, mul_finish
    );

    // Requesters and multiplier side
    modport master (
        output req0_valid, req0_a, req0_b, req0_signed,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_signed,
        input  req1_ready,
        input  rsp0_valid, rsp0_product, rsp0_err,
        output rsp0_ready,
        input  rsp1_valid, rsp1_product, rsp1_err,
        output rsp1_ready,
        input  mul_start, mul_multiplicand, mul_multiplier,
        output mul_product, mul_finish
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin two-way arbiter and sequencer for the shared shift-add multiplier,
// with sign/magnitude handling for signed operands and a WAIT watchdog.
`timescale 1ns/1ps
module mul_arbiter #(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_arbiter_if.slave  bus
);
    localparam int unsigned OP_W   = 32;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]             state_q, state_d;
    logic                   last_q, last_d;
    logic                   owner_q, owner_d;
    logic                   neg_q, neg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   start_q, start_d;
    logic [OP_W-1:0]        mcand_q, mcand_d;
    logic [OP_W-1:0]        mplier_q, mplier_d;
    logic [1:0]             valid_q, valid_d;
    logic [1:0][PROD_W-1:0] prod_q, prod_d;
    logic [1:0]             err_q, err_d;

    logic [1:0]             req_ready_c;
    logic                   grant0, grant1;
    logic                   sel_signed;
    logic [OP_W-1:0]        sel_a, sel_b;
    logic                   rsp_ready_sel;
    logic [PROD_W-1:0]      result;

    // Magnitude of a two's-complement operand; 0x8000_0000 maps to itself as unsigned
    function automatic logic [OP_W-1:0] mag(input logic [OP_W-1:0] x, input logic sgn);
        return (sgn && x[OP_W-1]) ? (~x + OP_W'(1)) : x;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            valid_q  <= '0;
            prod_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            valid_q  <= valid_d;
            prod_q   <= prod_d;
            err_q    <= err_d;
        end
    end

    // Next-state, grant and next-output logic
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        owner_d       = owner_q;
        neg_d         = neg_q;
        cnt_d         = cnt_q;
        start_d       = 1'b0;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        valid_d       = valid_q;
        prod_d        = prod_q;
        err_d         = err_q;
        req_ready_c   = '0;
        result        = '0;

        grant0        = bus.req0_valid && (!bus.req1_valid || last_q);
        grant1        = bus.req1_valid && (!bus.req0_valid || !last_q);
        sel_signed    = grant1 ? bus.req1_signed : bus.req0_signed;
        sel_a         = grant1 ? bus.req1_a : bus.req0_a;
        sel_b         = grant1 ? bus.req1_b : bus.req0_b;
        rsp_ready_sel = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

        case (state_q)
            S_IDLE: begin
                req_ready_c = {grant1, grant0} & {2{rst_n}};
                if (grant0 || grant1) begin
                    owner_d  = grant1;
                    last_d   = grant1;
                    mcand_d  = mag(sel_a, sel_signed);
                    mplier_d = mag(sel_b, sel_signed);
                    neg_d    = sel_signed && (sel_a[OP_W-1] ^ sel_b[OP_W-1]);
                    start_d  = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // finish is still high from the previous operation in the first WAIT cycle
                if ((cnt_q != '0) && bus.mul_finish) begin
                    result           = neg_q ? (~bus.mul_product + PROD_W'(1)) : bus.mul_product;
                    prod_d[owner_q]  = result;
                    err_d[owner_q]   = 1'b0;
                    valid_d[owner_q] = 1'b1;
                    state_d          = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    prod_d[owner_q]  = '0;
                    err_d[owner_q]   = 1'b1;
                    valid_d[owner_q] = 1'b1;
                    state_d          = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (rsp_ready_sel) begin
                    valid_d[owner_q] = 1'b0;
                    state_d          = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req0_ready       = req_ready_c[0];
    assign bus.req1_ready       = req_ready_c[1];
    assign bus.rsp0_valid       = valid_q[0];
    assign bus.rsp1_valid       = valid_q[1];
    assign bus.rsp0_product     = prod_q[0];
    assign bus.rsp1_product     = prod_q[1];
    assign bus.rsp0_err         = err_q[0];
    assign bus.rsp1_err         = err_q[1];
    assign bus.mul_start        = start_q;
    assign bus.mul_multiplicand = mcand_q;
    assign bus.mul_multiplier   = mplier_q;
endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Sequencing controller and two-way arbiter for the shared 32-cycle shift-add multiplier (the unit with the `start`/`finish` handshake, `multiplicand`/`multiplier` operands and a 64-bit `product`). Two requesters issue multiply requests with valid/ready handshakes. The block grants them round-robin, drives one multiplier operation at a time and returns the 64-bit result on the winning requester's response channel. It also adds signed-operand support by sign/magnitude conversion around the unsigned multiplier, and a watchdog against a hung unit.

## Interface
- TIMEOUT, 40, maximum cycles in WAIT before the operation is aborted with error
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  (N=0,1) request present
- reqN_ready  out  1  request accepted this cycle
- reqN_a, reqN_b  in  32 each  operands
- reqN_signed  in  1  operands are two's-complement
- rspN_valid  out  1  result available to requester N
- rspN_ready  in  1  requester N takes result
- rspN_product  out  64  result
- rspN_err  out  1  result invalid (watchdog abort)
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_multiplicand, mul_multiplier  out  32 each  operands to multiplier, held stable from ISSUE to end of WAIT
- mul_product  in  64  multiplier result
- mul_finish  in  1  multiplier done (level, stays high until next start)

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - `reqN_ready` = `reqN_valid` && (N is granted). Granted requester: the only valid one, or, if both are valid, the one not granted last. The last-grant pointer resets to 1, so requester 0 wins first.
  - On handshake, latch operands, signed flag and owner; update pointer; go to ISSUE.
- Operand conditioning:
  - Signed: magnitude of each operand (|−2^31| = 0x8000_0000 fits unsigned); neg = a[31]^b[31].
  - Unsigned: operands pass through; neg = 0.
- ISSUE: `mul_start`=1 for exactly one cycle; clear watchdog counter; go to WAIT.
- WAIT:
  - `mul_finish` is ignored in the first WAIT cycle. On a later `mul_finish`=1, capture `mul_product` into the result register, two's-complement negated (64-bit) if neg; err=0; go to DONE.
  - If the counter reaches TIMEOUT: result=0, err=1, go to DONE.
- DONE: only the owner's `rspN_valid`=1 with product/err. On `rspN_ready`, go to IDLE. The other requester stays blocked; no request is accepted in ISSUE/WAIT/DONE.
- Arbitration never preempts. A requester dropping `valid` before its handshake is legal and loses nothing.
- Reset (any time, including mid-WAIT): state=IDLE, pointer=1, all outputs 0 (`reqN_ready`, `rspN_valid`, `rspN_product`, `rspN_err`, `mul_start`, `mul_multiplicand`, `mul_multiplier`). The multiplier is reset by the same system reset.

## Timing
- Handshake at edge E.
- `mul_start` is high during cycle E..E+1; the multiplier samples it at E+1.
- The multiplier raises `mul_finish` after edge E+34. The result is captured at E+35, and `rspN_valid` is high from E+35.
- Request-to-response latency is 35 cycles. With `rspN_ready` tied high, the next grant is possible at E+37 (DONE one cycle, IDLE handshake).
- Responses are registered; `reqN_ready` is combinational from `reqN_valid` and the pointer in IDLE.
- TIMEOUT counts WAIT cycles from entry. The default of 40 is larger than the nominal 34, so normal operations never trip it.

## Test plan
- Unsigned: req0 a=0x0000_0003, b=0x0000_0005 -> rsp0_product=0x0000_0000_0000_000F 35 cycles after handshake, err=0, mul_start pulse exactly 1 cycle.
- Signed: req1 a=0xFFFF_FFFE (−2), b=0x0000_0007, signed=1 -> rsp1_product=0xFFFF_FFFF_FFFF_FFF2. Also a=b=0x8000_0000, signed=1 -> 0x4000_0000_0000_0000.
- Arbitration: both valid continuously from reset -> grants 0,1,0,1; each requester's response carries its own product; no rsp on the idle port.
- Backpressure: rsp0_ready low for 10 cycles -> rsp0_valid and product held; req1_ready stays 0 until the response is taken.
- Watchdog: mul_finish stuck 0 -> rspN_err=1, product=0 after TIMEOUT WAIT cycles; the next request completes normally.
- Reset mid-WAIT: rst_n low at cycle 20 of an operation -> all outputs 0 immediately; after release, a new req0 3×5 returns 15 with normal latency.
